// File: rtl/ysyx_22040759_br_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22040759_br_ctrl
//  Brief    : EX-stage branch resolution controller. Detects a mispredicted
//             static-not-taken fetch, raises a one-cycle flush and holds a
//             redirect to the IFU until accepted. Also keeps branch counters.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040759_br_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic             ex_is_br,
    input  logic [XLEN-1:0]  ex_next_pc,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             flush,
    output logic             redir_valid,
    output logic [XLEN-1:0]  redir_pc,
    input  logic             redir_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] mis_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } state_e;

    localparam logic [XLEN-1:0]  C_PC_STEP = XLEN'(4);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic             flush_q, flush_d;
    logic             redir_valid_q, redir_valid_d;
    logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic ex_fire;
    logic br_taken;
    logic mispredict;

    // EX may only hand over an instruction while no redirect is outstanding.
    assign ex_ready   = (state_q == ST_IDLE);
    assign ex_fire    = ex_valid & ex_ready & ex_is_br;
    assign br_taken   = (ex_next_pc != (ex_pc + C_PC_STEP));
    assign mispredict = ex_fire & (ex_next_pc != pred_pc);

    // Next-state logic: enter REDIR on a mispredict, leave on the IFU handshake.
    always_comb begin
        state_d       = state_q;
        flush_d       = 1'b0;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mispredict) begin
                    state_d       = ST_REDIR;
                    flush_d       = 1'b1;
                    redir_valid_d = 1'b1;
                    redir_pc_d    = ex_next_pc;
                end
            end
            ST_REDIR: begin
                if (redir_valid_q && redir_ready) begin
                    state_d       = ST_IDLE;
                    redir_valid_d = 1'b0;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                redir_valid_d = 1'b0;
            end
        endcase
    end

    // Counter update; a clear wins over any increment in the same cycle.
    always_comb begin
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        mis_cnt_d   = mis_cnt_q;
        if (cnt_clr) begin
            br_cnt_d    = '0;
            taken_cnt_d = '0;
            mis_cnt_d   = '0;
        end else begin
            if (ex_fire)            br_cnt_d    = br_cnt_q + C_CNT_ONE;
            if (ex_fire && br_taken) taken_cnt_d = taken_cnt_q + C_CNT_ONE;
            if (mispredict)         mis_cnt_d   = mis_cnt_q + C_CNT_ONE;
        end
    end

    // State, redirect and counter registers; reset drops any pending redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            br_cnt_q      <= '0;
            taken_cnt_q   <= '0;
            mis_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            flush_q       <= flush_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            br_cnt_q      <= br_cnt_d;
            taken_cnt_q   <= taken_cnt_d;
            mis_cnt_q     <= mis_cnt_d;
        end
    end

    assign flush       = flush_q;
    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;
    assign br_cnt      = br_cnt_q;
    assign taken_cnt   = taken_cnt_q;
    assign mis_cnt     = mis_cnt_q;

endmodule
`default_nettype wire

// File: doc/ysyx_22040759_br_ctrl.md
Name: ysyx_22040759_br_ctrl

Overview:
Branch-resolution controller for the EX stage of the ysyx_22040759 core. It consumes the next-PC result of the B-type branch unit and the PC that fetch actually followed, and detects a misprediction; fetch runs static not-taken, so the PC it followed is pc+4. On a misprediction it issues a one-cycle pipeline flush and a held redirect to the IFU under a valid/ready handshake. It back-pressures EX while a redirect is outstanding and keeps branch performance counters.

Parameters:
XLEN, 64, PC and target width
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX stage holds a valid instruction
ex_ready  out  1  controller can accept an EX instruction this cycle
ex_is_br  in  1  EX instruction is a B-type branch
ex_next_pc  in  XLEN  resolved next PC from the branch unit (target if taken, else pc+4)
ex_pc  in  XLEN  PC of the EX instruction
pred_pc  in  XLEN  PC of the instruction fetch followed after ex_pc
flush  out  1  kill IF/ID/EX-latch contents (younger instructions)
redir_valid  out  1  redirect request to IFU
redir_pc  out  XLEN  redirect target
redir_ready  in  1  IFU accepts redirect
cnt_clr  in  1  synchronous clear of all counters
br_cnt  out  CNT_W  branches resolved
taken_cnt  out  CNT_W  branches resolved taken
mis_cnt  out  CNT_W  mispredictions

Behaviour:
- Reset (asynchronous, any state): state=IDLE; flush=0, redir_valid=0, redir_pc=0, all counters=0. Takes effect immediately, including mid-REDIR; a pending redirect is dropped.
- ex_fire = ex_valid & ex_ready & ex_is_br.
- taken = (ex_next_pc != ex_pc+4), computed at XLEN bits, wrap-around ignored.
- mispredict = ex_fire & (ex_next_pc != pred_pc).
- ex_ready = (state==IDLE). It is combinational from state only; there is no path from ex_* inputs.
- Non-branch instructions (ex_is_br=0) are ignored: no counters change and there is no flush.
- FSM:
  - IDLE: on mispredict in cycle T, register redir_pc<=ex_next_pc and go to REDIR. flush=1 and redir_valid=1 during T+1. No mispredict: stay IDLE.
  - REDIR: flush=1 only in the first REDIR cycle, then 0. redir_valid=1 and redir_pc stays stable until redir_valid&redir_ready. On the handshake, return to IDLE next cycle with redir_valid=0. If ready is high in the first REDIR cycle, REDIR lasts exactly 1 cycle.
  - Minimum mispredict penalty: ex_ready=0 for 1 cycle.
- ex_valid inputs while ex_ready=0 are not consumed and not counted. EX must hold them; after a flush they are wrong-path and are killed upstream.
- Counters are registered and wrap modulo 2^CNT_W.
  - br_cnt += 1 on ex_fire.
  - taken_cnt += 1 on ex_fire&taken.
  - mis_cnt += 1 on mispredict.
  - cnt_clr has priority: if cnt_clr and an increment occur in the same cycle, the counter is 0 next cycle.
- Correct prediction (ex_next_pc==pred_pc), including a taken branch whose pred_pc already equals the target: no flush, no redirect, ex_ready stays 1, back-to-back branches accepted every cycle.
- All outputs registered except ex_ready.

Test Plan:
- Reset release, then a not-taken branch: ex_pc=0x80000000, ex_next_pc=pred_pc=0x80000004 -> flush=0, redir_valid=0, br_cnt=1, taken_cnt=0, mis_cnt=0.
- Taken mispredict: ex_pc=0x80000010, ex_next_pc=0x80000100, pred_pc=0x80000014, redir_ready=1 -> next cycle flush=1, redir_valid=1, redir_pc=0x80000100; ex_ready=0 for exactly 1 cycle; mis_cnt=1, taken_cnt=1.
- IFU back-pressure: same mispredict with redir_ready=0 for 3 cycles then 1 -> redir_valid held 4 cycles with redir_pc stable; flush high only in the first; ex_valid branches presented meanwhile are not counted.
- Reset mid-REDIR: assert rst_n=0 in the second REDIR cycle -> redir_valid and flush drop immediately, state IDLE, counters 0 after release.
- Counter wrap and clear, CNT_W=4: 16 branches -> br_cnt wraps to 0; cnt_clr coincident with a mispredict -> all counters 0 next cycle.
- Back-to-back correctly predicted branches, 8 consecutive cycles -> ex_ready stays 1, br_cnt=8, no flush.
